// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier among N requesters,
// with a watchdog that aborts and returns an error response if done never arrives.
module mult_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     rsp_valid,
    output logic [2*W-1:0]   rsp_p,
    output logic             rsp_err,
    output logic             mul_st,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_idle,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_p
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant;
    logic            grant_any;
    logic [CW-1:0]   wdog;
    logic [2*W-1:0]  prod;
    logic            err;
    logic            wdog_exp;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    assign wdog_exp = (wdog == CW'(TIMEOUT - 1));

    // Scan from the farthest offset down so the first valid index at/after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant     = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        mul_st    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant] = 1'b1;
                    state_nx         = START;
                end
            end
            START: begin
                if (mul_idle) begin
                    mul_st   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (mul_done || wdog_exp) state_nx = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Response data is gated so the bus reads zero outside the strobe cycle.
    assign rsp_p   = (state == RESP) ? prod : '0;
    assign rsp_err = (state == RESP) & err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            wdog   <= '0;
            prod   <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner <= grant;
                        mul_a <= req_a[grant*W +: W];
                        mul_b <= req_b[grant*W +: W];
                    end
                end
                START: begin
                    if (mul_idle) wdog <= '0;
                end
                WAIT: begin
                    wdog <= wdog + CW'(1);
                    // A done arriving on the timeout cycle still counts as success.
                    if (mul_done) begin
                        prod <= mul_p;
                        err  <= 1'b0;
                    end else if (wdog_exp) begin
                        prod <= '0;
                        err  <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
